wb_controller: RTL and testbench
================================

WB_CONTROLLER -- requirements
Module: wb_controller

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, default 16, maximum WAIT cycles per load; legal range 1..255.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk only.
REQ-004 SHALL have port: InstrValid  input  1  decoded instruction present this cycle.
REQ-005 SHALL have port: ResultSrcDec  input  3  decoder result-source code (000 ALU, 001 mem, 010 PC+4, 011 imm, 100 PC target).
REQ-006 SHALL have port: RegWriteDec  input  1  decoder register-write request.
REQ-007 SHALL have port: RdDec  input  5  destination register index.
REQ-008 SHALL have port: MemAck  input  1  load data valid on the MemoryData bus this cycle.
REQ-009 SHALL have port: ResultSrc  output  3  select driven to the result-source mux.
REQ-010 SHALL have port: RegWrite  output  1  register-file write enable.
REQ-011 SHALL have port: RegWriteAddr  output  5  register-file write index.
REQ-012 SHALL have port: Stall  output  1  hold the PC and instruction for this cycle.
REQ-013 SHALL have port: MemReq  output  1  load request to data memory.
REQ-014 SHALL have port: LoadTimeout  output  1  sticky flag: a load was abandoned.
REQ-015 SHALL have port: IllegalSrc  output  1  sticky flag: a ResultSrcDec code of 101..111 was seen with InstrValid=1.

Function
REQ-016 SHALL implement a two-state FSM: IDLE and WAIT, plus an 8-bit wait counter.
REQ-017 In IDLE with InstrValid=1 and ResultSrcDec in {000,010,011,100}, SHALL drive ResultSrc=ResultSrcDec, RegWriteAddr=RdDec, RegWrite=RegWriteDec & (RdDec!=0), Stall=0, and stay in IDLE.
REQ-018 In IDLE with InstrValid=1, ResultSrcDec=001 and RegWriteDec=1, SHALL drive Stall=1 and RegWrite=0, latch RdDec, clear the counter, and enter WAIT on the next edge.
REQ-019 In IDLE with InstrValid=1, ResultSrcDec=001 and RegWriteDec=0, SHALL treat the instruction as a non-load: no stall and no write.
REQ-020 In WAIT, SHALL drive MemReq=1, ResultSrc=001 and RegWriteAddr=latched rd; MemReq SHALL be 0 in every IDLE cycle.
REQ-021 In WAIT with MemAck=1, SHALL drive RegWrite=(latched rd!=0) and Stall=0 in the same cycle, and return to IDLE on the next edge.
REQ-022 In WAIT with MemAck=0, SHALL drive Stall=1 and RegWrite=0, and increment the counter.
REQ-023 In the WAIT cycle where counter==TIMEOUT_CYCLES-1 and MemAck=0, SHALL drive Stall=0 and RegWrite=0, set LoadTimeout on the next edge, and return to IDLE; WAIT therefore lasts at most TIMEOUT_CYCLES cycles.
REQ-024 If MemAck arrives on the final permitted WAIT cycle, the ack SHALL take precedence: the write occurs and LoadTimeout is not set.
REQ-025 MemAck in IDLE SHALL be ignored.
REQ-026 In IDLE with InstrValid=0, SHALL drive RegWrite=0 and Stall=0.
REQ-027 For an illegal code (101..111) in IDLE with InstrValid=1, SHALL drive RegWrite=0, Stall=0 and ResultSrc=000, and set IllegalSrc on the next edge.
REQ-028 SHALL never drive RegWrite=1 with RegWriteAddr=0.
REQ-029 Inputs in WAIT other than MemAck SHALL be ignored, because the upstream instruction is held by Stall.

Reset
REQ-030 With reset_n=0 at a rising edge, SHALL enter IDLE and clear the counter, the latched rd, LoadTimeout and IllegalSrc.
REQ-031 A reset in WAIT SHALL abandon the load, with MemReq=0 from the first post-reset cycle and no register write.
REQ-032 While reset_n=0, RegWrite, Stall and MemReq SHALL be forced to 0 and ResultSrc to 000.

Verification
REQ-033 ALU op: InstrValid=1, ResultSrcDec=000, RegWriteDec=1, RdDec=5 -> same cycle RegWrite=1, RegWriteAddr=5, ResultSrc=000, Stall=0.
REQ-034 Load with 3-cycle latency: load to rd=7 at cycle N, MemAck=1 at N+3 -> Stall=1 in N..N+2; MemReq=1 in N+1..N+3; RegWrite=1, RegWriteAddr=7, ResultSrc=001, Stall=0 at N+3; MemReq=0 at N+4.
REQ-035 Timeout with TIMEOUT_CYCLES=4, no MemAck -> WAIT for 4 cycles; last WAIT cycle Stall=0 and RegWrite=0; LoadTimeout=1 thereafter, until reset.
REQ-036 Ack on final WAIT cycle (TIMEOUT_CYCLES=4, ack on WAIT cycle 4) -> RegWrite=1 and LoadTimeout remains 0.
REQ-037 x0 and illegal code: load to rd=0 -> full stall sequence with RegWrite=0 throughout; ResultSrcDec=110 with InstrValid=1 -> RegWrite=0 and IllegalSrc=1 next cycle.
REQ-038 Reset mid-WAIT: reset_n=0 on WAIT cycle 2 -> next cycle IDLE, MemReq=0, RegWrite=0, both flags 0.

Source files
------------

// File: rtl/wb_controller.sv
// Writeback controller: selects the result source, gates register writes and
// stalls the front end while a load waits for MemAck, with a bounded timeout.
module wb_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       InstrValid,
    input  logic [2:0] ResultSrcDec,
    input  logic       RegWriteDec,
    input  logic [4:0] RdDec,
    input  logic       MemAck,
    output logic [2:0] ResultSrc,
    output logic       RegWrite,
    output logic [4:0] RegWriteAddr,
    output logic       Stall,
    output logic       MemReq,
    output logic       LoadTimeout,
    output logic       IllegalSrc,
    output logic       fsm_state
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [2:0] SRC_ALU = 3'b000;
    localparam logic [2:0] SRC_MEM = 3'b001;
    localparam logic [2:0] SRC_MAX = 3'b100;
    localparam logic [7:0] LAST    = 8'(TIMEOUT_CYCLES - 1);

    state_t     state, state_next;
    logic [7:0] count, count_next;
    logic [4:0] rd_q, rd_next;
    logic       timeout_set;
    logic       illegal_set;

    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            count       <= 8'd0;
            rd_q        <= 5'd0;
            LoadTimeout <= 1'b0;
            IllegalSrc  <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            rd_q  <= rd_next;
            if (timeout_set) LoadTimeout <= 1'b1;
            if (illegal_set) IllegalSrc  <= 1'b1;
        end
    end

    always_comb begin
        state_next   = state;
        count_next   = count;
        rd_next      = rd_q;
        ResultSrc    = SRC_ALU;
        RegWrite     = 1'b0;
        RegWriteAddr = RdDec;
        Stall        = 1'b0;
        MemReq       = 1'b0;
        timeout_set  = 1'b0;
        illegal_set  = 1'b0;

        case (state)
            IDLE: begin
                if (InstrValid) begin
                    if (ResultSrcDec == SRC_MEM) begin
                        // A mem-source op without a write is treated as a plain non-load.
                        ResultSrc = SRC_MEM;
                        if (RegWriteDec) begin
                            Stall      = 1'b1;
                            rd_next    = RdDec;
                            count_next = 8'd0;
                            state_next = WAIT;
                        end
                    end else if (ResultSrcDec > SRC_MAX) begin
                        illegal_set = 1'b1;
                    end else begin
                        ResultSrc = ResultSrcDec;
                        RegWrite  = RegWriteDec && (RdDec != 5'd0);
                    end
                end
            end
            WAIT: begin
                MemReq       = 1'b1;
                ResultSrc    = SRC_MEM;
                RegWriteAddr = rd_q;
                // Ack wins over timeout on the final permitted cycle.
                if (MemAck) begin
                    RegWrite   = (rd_q != 5'd0);
                    state_next = IDLE;
                end else if (count == LAST) begin
                    timeout_set = 1'b1;
                    state_next  = IDLE;
                end else begin
                    Stall      = 1'b1;
                    count_next = count + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (!reset_n) begin
            ResultSrc = SRC_ALU;
            RegWrite  = 1'b0;
            Stall     = 1'b0;
            MemReq    = 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_controller.sv
// Bench for wb_controller: transaction-level reference (ALU op, load with a
// chosen ack latency, idle, reset mid-load) expanded into per-cycle expectations.
module tb_wb_controller;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       InstrValid = 1'b0;
    logic [2:0] ResultSrcDec = 3'd0;
    logic       RegWriteDec = 1'b0;
    logic [4:0] RdDec = 5'd0;
    logic       MemAck = 1'b0;
    logic [2:0] ResultSrc;
    logic       RegWrite;
    logic [4:0] RegWriteAddr;
    logic       Stall;
    logic       MemReq;
    logic       LoadTimeout;
    logic       IllegalSrc;
    logic       fsm_state;

    wb_controller #(.TIMEOUT_CYCLES(T)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .InstrValid  (InstrValid),
        .ResultSrcDec(ResultSrcDec),
        .RegWriteDec (RegWriteDec),
        .RdDec       (RdDec),
        .MemAck      (MemAck),
        .ResultSrc   (ResultSrc),
        .RegWrite    (RegWrite),
        .RegWriteAddr(RegWriteAddr),
        .Stall       (Stall),
        .MemReq      (MemReq),
        .LoadTimeout (LoadTimeout),
        .IllegalSrc  (IllegalSrc),
        .fsm_state   (fsm_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [4:0] exp_q[$];

    logic [2:0] e_src;
    logic       e_rw, e_stall, e_memreq, e_timeout, e_illegal, chk_src, chk_addr;
    logic [4:0] e_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_exp(input logic [2:0] src, input logic cs, input logic rw,
                           input logic [4:0] addr, input logic ca, input logic stall,
                           input logic memreq);
        e_src = src; chk_src = cs; e_rw = rw; e_addr = addr; chk_addr = ca;
        e_stall = stall; e_memreq = memreq;
    endtask

    // Drive one cycle's inputs after the falling edge, then compare outputs.
    task automatic step(input logic rst, input logic iv, input logic [2:0] src,
                        input logic rwd, input logic [4:0] rd, input logic ack);
        @(negedge clk);
        reset_n = rst; InstrValid = iv; ResultSrcDec = src;
        RegWriteDec = rwd; RdDec = rd; MemAck = ack;
        #1;
        if (chk_src) check("result_src", ResultSrc, e_src);
        check("reg_write", RegWrite, e_rw);
        if (chk_addr) check("write_addr", RegWriteAddr, e_addr);
        check("stall", Stall, e_stall);
        check("mem_req", MemReq, e_memreq);
        check("load_timeout", LoadTimeout, e_timeout);
        check("illegal_src", IllegalSrc, e_illegal);
        check("x0_write", RegWrite && (RegWriteAddr == 5'd0), 0);
        if (RegWrite === 1'b1) begin
            if (exp_q.size() == 0) check("unexpected_write", RegWrite, 0);
            else check("sb_write_addr", RegWriteAddr, exp_q.pop_front());
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic op_alu(input logic [2:0] src, input logic rwd, input logic [4:0] rd);
        logic rw;
        if (src == 3'b001) begin
            set_exp(3'b001, 1'b1, 1'b0, rd, 1'b0, 1'b0, 1'b0);
            step(1'b1, 1'b1, src, 1'b0, rd, rbit());
        end else if (src > 3'b100) begin
            set_exp(3'b000, 1'b1, 1'b0, rd, 1'b0, 1'b0, 1'b0);
            step(1'b1, 1'b1, src, rwd, rd, rbit());
            e_illegal = 1'b1;
        end else begin
            rw = rwd && (rd != 5'd0);
            set_exp(src, 1'b1, rw, rd, 1'b1, 1'b0, 1'b0);
            if (rw) exp_q.push_back(rd);
            step(1'b1, 1'b1, src, rwd, rd, rbit());
        end
    endtask

    // lat = WAIT cycle (1-based) on which MemAck arrives; outside 1..T means never.
    task automatic op_load(input logic [4:0] rd, input int lat);
        logic ack, rw, stall;
        set_exp(3'b001, 1'b0, 1'b0, rd, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 3'b001, 1'b1, rd, rbit());
        for (int k = 1; k <= T; k++) begin
            ack   = (k == lat);
            rw    = ack && (rd != 5'd0);
            stall = !ack && (k != T);
            set_exp(3'b001, 1'b1, rw, rd, 1'b1, stall, 1'b1);
            if (rw) exp_q.push_back(rd);
            step(1'b1, rbit(), 3'($urandom_range(0, 7)), rbit(), 5'($urandom), ack);
            if (ack) break;
            if (k == T) e_timeout = 1'b1;
        end
    endtask

    task automatic op_idle();
        set_exp(3'b000, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 3'($urandom_range(0, 7)), rbit(), 5'($urandom), rbit());
    endtask

    task automatic op_reset_cycle();
        set_exp(3'b000, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, rbit(), 3'($urandom_range(0, 7)), rbit(), 5'($urandom), rbit());
        e_timeout = 1'b0;
        e_illegal = 1'b0;
    endtask

    task automatic op_reset_mid_wait(input logic [4:0] rd);
        set_exp(3'b001, 1'b0, 1'b0, rd, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 3'b001, 1'b1, rd, 1'b0);
        set_exp(3'b001, 1'b1, 1'b0, rd, 1'b1, 1'b1, 1'b1);
        step(1'b1, rbit(), 3'($urandom_range(0, 7)), rbit(), 5'($urandom), 1'b0);
        op_reset_cycle();
        op_idle();
    endtask

    function automatic logic [4:0] rand_rd();
        return ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    endfunction

    initial begin
        e_timeout = 1'b0;
        e_illegal = 1'b0;
        repeat (3) op_reset_cycle();

        op_alu(3'b000, 1'b1, 5'd5);
        op_load(5'd7, 3);
        op_idle();
        op_load(5'd9, T);
        op_load(5'd0, 2);
        op_load(5'd0, 0);
        op_alu(3'b110, 1'b1, 5'd3);
        op_idle();
        op_load(5'd12, 0);
        repeat (2) op_idle();
        op_reset_mid_wait(5'd4);

        for (int i = 0; i < 400; i++) begin
            int r;
            logic [2:0] src;
            r = $urandom_range(0, 9);
            if (r <= 3) begin
                src = 3'($urandom_range(0, 7));
                op_alu(src, (src == 3'b001) ? 1'b0 : rbit(), rand_rd());
            end else if (r <= 6) begin
                op_load(rand_rd(), $urandom_range(0, T + 1));
            end else if (r <= 8) begin
                op_idle();
            end else begin
                op_reset_mid_wait(rand_rd());
            end
        end

        check("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
